// File: rtl/aes_avalon_regfile_p.sv
// aes_avalon_regfile_p
// Avalon-MM register file that sits in front of a block-cipher engine.
// Holds key / msg_in / result banks of BLOCK_WORDS words, a spare scratch
// area, CTRL and a read-only STATUS word. A start/done handshake drives the
// engine, with a cycle timeout and a software abort.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   avl_*               Avalon-MM slave; readdata has a fixed latency of 1
//   eng_start           one-cycle start pulse to the engine
//   eng_key / eng_msg   key / input-block snapshot taken at start, word 0 in MSBs
//   eng_done            single-cycle result strobe from the engine
//   eng_result          engine result, sampled while eng_done is high
//   export_sel          export source: 0 key, 1 msg_in, 2 result, 3 STATUS
//   export_data         registered export for the hex displays
module aes_avalon_regfile_p #(
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          avl_chipselect,
    input  logic                          avl_read,
    input  logic                          avl_write,
    input  logic [ADDR_W-1:0]             avl_address,
    input  logic [DATA_W/8-1:0]           avl_byteenable,
    input  logic [DATA_W-1:0]             avl_writedata,
    output logic [DATA_W-1:0]             avl_readdata,
    output logic                          eng_start,
    output logic [BLOCK_WORDS*DATA_W-1:0] eng_key,
    output logic [BLOCK_WORDS*DATA_W-1:0] eng_msg,
    input  logic                          eng_done,
    input  logic [BLOCK_WORDS*DATA_W-1:0] eng_result,
    input  logic [1:0]                    export_sel,
    output logic [DATA_W-1:0]             export_data
);
    localparam int BW       = BLOCK_WORDS;
    localparam int NB       = DATA_W / 8;
    localparam int HALF     = DATA_W / 2;
    localparam int KEY_BASE = 0;
    localparam int MSG_BASE = BW;
    localparam int RES_BASE = 2 * BW;
    localparam int CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d, to_q, to_d;
    logic               start_go, load_result;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];   // STATUS slot is never written
    logic [DATA_W-1:0]  wr_mask, status_w, export_d;
    logic               wr_en, ctrl_wr, start_wr, abort_wr, busy;

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wr_mask[b*8 +: 8] = {8{avl_byteenable[b]}};
    end

    assign busy     = (state_q == S_RUN);
    assign status_w = {{(DATA_W-3){1'b0}}, busy, to_q, done_q};
    assign wr_en    = avl_chipselect & avl_write;
    assign ctrl_wr  = wr_en & (avl_address == CTRL_A);
    // START/ABORT only count when byte lane 0 is actually written
    assign start_wr = ctrl_wr & avl_byteenable[0] & avl_writedata[0];
    assign abort_wr = ctrl_wr & avl_byteenable[0] & avl_writedata[1];

    // Handshake FSM: next state and status bits
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        to_d        = to_q;
        start_go    = 1'b0;
        load_result = 1'b0;
        case (state_q)
            S_IDLE: start_go = start_wr;
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (abort_wr) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    to_d    = 1'b0;
                end else if (eng_done) begin
                    load_result = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_wr) begin
                    start_go = 1'b1;
                end else if (ctrl_wr) begin
                    done_d  = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start_go) begin
            state_d = S_RUN;
            cnt_d   = '0;
            done_d  = 1'b0;
            to_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    // Register banks, engine snapshot and start pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            eng_start <= 1'b0;
            eng_key   <= '0;
            eng_msg   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                // result bank belongs to the engine while a run is in flight
                if (wr_en && avl_address == ADDR_W'(i) &&
                    !(busy && i >= RES_BASE && i < RES_BASE + BW))
                    regs_q[i] <= (regs_q[i] & ~wr_mask) | (avl_writedata & wr_mask);
            end
            if (load_result) begin
                for (int w = 0; w < BW; w++)
                    regs_q[RES_BASE+w] <= eng_result[(BW-1-w)*DATA_W +: DATA_W];
            end
            eng_start <= start_go;
            if (start_go) begin
                for (int w = 0; w < BW; w++) begin
                    eng_key[(BW-1-w)*DATA_W +: DATA_W] <= regs_q[KEY_BASE+w];
                    eng_msg[(BW-1-w)*DATA_W +: DATA_W] <= regs_q[MSG_BASE+w];
                end
            end
        end
    end

    always_comb begin
        export_d = status_w;
        case (export_sel)
            2'd0: export_d = {regs_q[KEY_BASE][DATA_W-1:HALF], regs_q[KEY_BASE+BW-1][HALF-1:0]};
            2'd1: export_d = {regs_q[MSG_BASE][DATA_W-1:HALF], regs_q[MSG_BASE+BW-1][HALF-1:0]};
            2'd2: export_d = {regs_q[RES_BASE][DATA_W-1:HALF], regs_q[RES_BASE+BW-1][HALF-1:0]};
            default: export_d = status_w;
        endcase
    end

    // Read port samples pre-write contents, so read+write returns the old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avl_readdata <= '0;
            export_data  <= '0;
        end else begin
            if (avl_chipselect && avl_read)
                avl_readdata <= (avl_address == STAT_A) ? status_w : regs_q[avl_address];
            export_data <= export_d;
        end
    end

endmodule
